// File: rtl/gpr_pkg.sv
// Shared constants and helpers for the scoreboarded GPR file.
// Latency: n/a (types, defaults and a pure function only).
// Backpressure: n/a.
package gpr_pkg;

   localparam int GPR_WIDTH    = 32;
   localparam int GPR_DEPTH    = 32;
   localparam int GPR_ZERO_REG = 1;
   localparam int GPR_BYPASS   = 1;

   // Direction of the busy counter's step for one cycle.
   typedef enum logic [1:0] {
      CNT_HOLD = 2'd0,
      CNT_INC  = 2'd1,
      CNT_DEC  = 2'd2
   } cnt_delta_e;

   // set_new: a clear bit becomes busy; clr_old: a busy bit is released.
   // They always touch different indices, so both together cancel out.
   function automatic cnt_delta_e busy_delta(input logic set_new, input logic clr_old);
      cnt_delta_e d;
      d = CNT_HOLD;
      if (set_new && !clr_old)
         d = CNT_INC;
      else if (clr_old && !set_new)
         d = CNT_DEC;
      return d;
   endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy scoreboard: reserve on issue, release on writeback.
// Latency: Sr_ok/Rdya/Rdyb combinational; busy and busy_cnt update on the clock edge.
// Backpressure: a WAW reserve (target busy, no same-cycle write) is refused via Sr_ok=0.
// Ports: clk/rst_n; write (Sw,Sc); reserve (Sr,Sd,Sr_ok); read ready (Sa,Sb,i_hit_a/b,Rdya,Rdyb);
//        status (busy, busy_cnt).
module gpr_scoreboard
   import gpr_pkg::*;
#(
   parameter  int DEPTH    = GPR_DEPTH,
   parameter  int ZERO_REG = GPR_ZERO_REG,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          Sw,
   input  logic [AW-1:0] Sc,
   input  logic          Sr,
   input  logic [AW-1:0] Sd,
   input  logic [AW-1:0] Sa,
   input  logic [AW-1:0] Sb,
   input  logic          i_hit_a,
   input  logic          i_hit_b,
   output logic          Sr_ok,
   output logic          Rdya,
   output logic          Rdyb,
   output logic [DEPTH-1:0] busy,
   output logic [AW:0]   busy_cnt
);

   localparam logic [AW:0] CNT_ONE = 1;

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busy_nxt;
   logic [AW:0]      r_busy_cnt;
   logic             w_res_ok;
   logic             w_res_set;
   logic             w_wr_clr;
   logic             w_set_new;
   logic             w_clr_old;
   cnt_delta_e       w_delta;

   // A write in the same cycle frees the slot, so the reserve may chain behind it.
   assign w_res_ok  = Sr && (!r_busy[Sd] || (Sw && (Sc == Sd)));
   // Register 0 is accepted but never marked busy when hardwired to zero.
   assign w_res_set = w_res_ok && !((ZERO_REG != 0) && (Sd == '0));
   assign w_wr_clr  = Sw && !((ZERO_REG != 0) && (Sc == '0));

   // Reserve is applied after the write so it wins on a shared index.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_wr_clr)
         w_busy_nxt[Sc] = 1'b0;
      if (w_res_set)
         w_busy_nxt[Sd] = 1'b1;
   end

   assign w_set_new = w_res_set && !r_busy[Sd];
   assign w_clr_old = w_wr_clr && r_busy[Sc] && !(w_res_set && (Sd == Sc));
   assign w_delta   = busy_delta(w_set_new, w_clr_old);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         case (w_delta)
            CNT_INC: r_busy_cnt <= r_busy_cnt + CNT_ONE;
            CNT_DEC: r_busy_cnt <= r_busy_cnt - CNT_ONE;
            default: r_busy_cnt <= r_busy_cnt;
         endcase
      end
   end

   assign Sr_ok    = w_res_ok;
   assign Rdya     = !r_busy[Sa] || i_hit_a;
   assign Rdyb     = !r_busy[Sb] || i_hit_b;
   assign busy     = r_busy;
   assign busy_cnt = r_busy_cnt;

endmodule

// File: rtl/gpr_sb.sv
// Single-write dual-read GPR file with optional zero register, write bypass and busy scoreboard.
// Latency: reads combinational (bypass gives same-cycle write data); state updates on the clock edge.
// Backpressure: none on writes; reserve requests are refused on WAW via Sr_ok.
// Ports: clk/rst_n; write (Sw,Sc,Sin); reads (Sa,Sb -> Souta,Soutb,Rdya,Rdyb);
//        reserve (Sr,Sd -> Sr_ok); status (busy, busy_cnt).
module gpr_sb
   import gpr_pkg::*;
#(
   parameter  int WIDTH    = GPR_WIDTH,
   parameter  int DEPTH    = GPR_DEPTH,
   parameter  int ZERO_REG = GPR_ZERO_REG,
   parameter  int BYPASS   = GPR_BYPASS,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Sw,
   input  logic [AW-1:0]    Sc,
   input  logic [WIDTH-1:0] Sin,
   input  logic [AW-1:0]    Sa,
   input  logic [AW-1:0]    Sb,
   output logic [WIDTH-1:0] Souta,
   output logic [WIDTH-1:0] Soutb,
   output logic             Rdya,
   output logic             Rdyb,
   input  logic             Sr,
   input  logic [AW-1:0]    Sd,
   output logic             Sr_ok,
   output logic [DEPTH-1:0] busy,
   output logic [AW:0]      busy_cnt
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_wr_en;
   logic             w_zero_a;
   logic             w_zero_b;
   logic             w_hit_a;
   logic             w_hit_b;

   assign w_wr_en  = Sw && !((ZERO_REG != 0) && (Sc == '0));
   assign w_zero_a = (ZERO_REG != 0) && (Sa == '0);
   assign w_zero_b = (ZERO_REG != 0) && (Sb == '0);
   assign w_hit_a  = (BYPASS != 0) && Sw && (Sc == Sa) && !w_zero_a;
   assign w_hit_b  = (BYPASS != 0) && Sw && (Sc == Sb) && !w_zero_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else if (w_wr_en) begin
         r_mem[Sc] <= Sin;
      end
   end

   always_comb begin
      Souta = r_mem[Sa];
      if (w_zero_a)
         Souta = '0;
      else if (w_hit_a)
         Souta = Sin;
   end

   always_comb begin
      Soutb = r_mem[Sb];
      if (w_zero_b)
         Soutb = '0;
      else if (w_hit_b)
         Soutb = Sin;
   end

   gpr_scoreboard #(
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .Sw       (Sw),
      .Sc       (Sc),
      .Sr       (Sr),
      .Sd       (Sd),
      .Sa       (Sa),
      .Sb       (Sb),
      .i_hit_a  (w_hit_a),
      .i_hit_b  (w_hit_b),
      .Sr_ok    (Sr_ok),
      .Rdya     (Rdya),
      .Rdyb     (Rdyb),
      .busy     (busy),
      .busy_cnt (busy_cnt)
   );

endmodule

// File: tb/tb_gpr_sb.sv
// Bench for gpr_sb: a bypass build and a no-bypass build share one stimulus stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_gpr_sb;

   logic        clk;
   logic        rst_n;
   logic        Sw;
   logic [4:0]  Sc;
   logic [31:0] Sin;
   logic [4:0]  Sa;
   logic [4:0]  Sb;
   logic        Sr;
   logic [4:0]  Sd;

   logic [31:0] souta, soutb, souta_nb, soutb_nb;
   logic        rdya, rdyb, rdya_nb, rdyb_nb;
   logic        sr_ok, sr_ok_nb;
   logic [31:0] busy, busy_nb;
   logic [5:0]  busy_cnt, busy_cnt_nb;

   int total = 0;
   int bad   = 0;
   bit run_cmp = 0;

   // Reference state: plain register contents and a busy flag per register.
   logic [31:0] m_reg [32];
   logic [31:0] m_busy;

   gpr_sb dut (
      .clk(clk), .rst_n(rst_n), .Sw(Sw), .Sc(Sc), .Sin(Sin), .Sa(Sa), .Sb(Sb),
      .Souta(souta), .Soutb(soutb), .Rdya(rdya), .Rdyb(rdyb),
      .Sr(Sr), .Sd(Sd), .Sr_ok(sr_ok), .busy(busy), .busy_cnt(busy_cnt)
   );

   gpr_sb #(.BYPASS(0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .Sw(Sw), .Sc(Sc), .Sin(Sin), .Sa(Sa), .Sb(Sb),
      .Souta(souta_nb), .Soutb(soutb_nb), .Rdya(rdya_nb), .Rdyb(rdyb_nb),
      .Sr(Sr), .Sd(Sd), .Sr_ok(sr_ok_nb), .busy(busy_nb), .busy_cnt(busy_cnt_nb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int ones(input logic [31:0] v);
      int n = 0;
      for (int i = 0; i < 32; i++) if (v[i]) n++;
      return n;
   endfunction

   function automatic bit hit(input logic [4:0] a, input bit byp);
      return byp && Sw && (Sc == a) && (a != 5'd0);
   endfunction

   function automatic logic [31:0] exp_out(input logic [4:0] a, input bit byp);
      if (a == 5'd0) return 32'd0;
      if (hit(a, byp)) return Sin;
      return m_reg[a];
   endfunction

   function automatic bit exp_ok();
      return Sr && (!m_busy[Sd] || (Sw && (Sc == Sd)));
   endfunction

   // Model update: a write stores data and frees its register; an accepted reserve
   // marks its register busy afterwards; register 0 never stores or becomes busy.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
         m_busy = 32'd0;
      end else begin
         bit ok;
         ok = exp_ok();
         if (Sw && Sc != 5'd0) begin
            m_reg[Sc]  = Sin;
            m_busy[Sc] = 1'b0;
         end
         if (ok && Sd != 5'd0) m_busy[Sd] = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         chk("souta",       souta,       exp_out(Sa, 1'b1));
         chk("soutb",       soutb,       exp_out(Sb, 1'b1));
         chk("rdya",        rdya,        !m_busy[Sa] || hit(Sa, 1'b1));
         chk("rdyb",        rdyb,        !m_busy[Sb] || hit(Sb, 1'b1));
         chk("sr_ok",       sr_ok,       exp_ok());
         chk("busy",        busy,        m_busy);
         chk("busy_cnt",    busy_cnt,    ones(m_busy));
         chk("souta_nb",    souta_nb,    exp_out(Sa, 1'b0));
         chk("soutb_nb",    soutb_nb,    exp_out(Sb, 1'b0));
         chk("rdya_nb",     rdya_nb,     !m_busy[Sa]);
         chk("rdyb_nb",     rdyb_nb,     !m_busy[Sb]);
         chk("sr_ok_nb",    sr_ok_nb,    exp_ok());
         chk("busy_nb",     busy_nb,     m_busy);
         chk("busy_cnt_nb", busy_cnt_nb, ones(m_busy));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      Sw = 1'b0; Sr = 1'b0; Sc = 5'd0; Sd = 5'd0; Sin = 32'd0;
   endtask

   function automatic logic [4:0] rnd_addr();
      if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
      return 5'($urandom_range(0, 31));
   endfunction

   initial begin
      rst_n = 1'b0;
      idle();
      Sa = 5'd0; Sb = 5'd0;
      step();
      run_cmp = 1'b1;
      step();
      rst_n = 1'b1;
      #1;
      chk("rst_busy",  busy,     32'd0);
      chk("rst_cnt",   busy_cnt, 6'd0);
      chk("rst_rdya",  rdya,     1'b1);
      chk("rst_souta", souta,    32'd0);

      // Reserve r5, then release it by writeback with bypass.
      Sr = 1'b1; Sd = 5'd5; Sa = 5'd5;
      #1 chk("res5_ok", sr_ok, 1'b1);
      step();
      idle(); Sa = 5'd5;
      #1;
      chk("res5_busy", busy[5],  1'b1);
      chk("res5_cnt",  busy_cnt, 6'd1);
      chk("res5_rdya", rdya,     1'b0);
      Sw = 1'b1; Sc = 5'd5; Sin = 32'hAAAA5555;
      #1;
      chk("byp5_rdya",     rdya,     1'b1);
      chk("byp5_souta",    souta,    32'hAAAA5555);
      chk("byp5_souta_nb", souta_nb, 32'd0);
      chk("byp5_rdya_nb",  rdya_nb,  1'b0);
      step();
      idle(); Sa = 5'd5;
      #1;
      chk("rel5_busy",  busy[5],  1'b0);
      chk("rel5_cnt",   busy_cnt, 6'd0);
      chk("rel5_souta", souta,    32'hAAAA5555);

      // Zero register: writes ignored, reserve accepted but never busy.
      Sw = 1'b1; Sc = 5'd0; Sin = 32'hDEADBEEF; Sa = 5'd0;
      #1 chk("z_wr_souta", souta, 32'd0);
      step();
      idle(); Sa = 5'd0;
      #1 chk("z_souta", souta, 32'd0);
      Sr = 1'b1; Sd = 5'd0;
      #1 chk("z_res_ok", sr_ok, 1'b1);
      step();
      idle();
      #1;
      chk("z_busy0", busy[0],  1'b0);
      chk("z_cnt",   busy_cnt, 6'd0);

      // WAW: refused without a write, accepted with a same-index write.
      Sr = 1'b1; Sd = 5'd10;
      step();
      Sr = 1'b1; Sd = 5'd10; Sw = 1'b0;
      #1 chk("waw_ok0", sr_ok, 1'b0);
      step();
      #1 chk("waw_cnt0", busy_cnt, 6'd1);
      Sw = 1'b1; Sc = 5'd10; Sin = 32'h12345678;
      #1 chk("waw_ok1", sr_ok, 1'b1);
      step();
      idle(); Sa = 5'd10;
      #1;
      chk("waw_souta", souta,    32'h12345678);
      chk("waw_busy",  busy[10], 1'b1);
      chk("waw_cnt1",  busy_cnt, 6'd1);

      // Reserve and write to different registers in one cycle.
      Sr = 1'b1; Sd = 5'd3; Sw = 1'b1; Sc = 5'd7; Sin = 32'h00000001;
      step();
      idle(); Sb = 5'd7;
      #1;
      chk("dist_busy3", busy[3],  1'b1);
      chk("dist_soutb", soutb,    32'h1);
      chk("dist_cnt",   busy_cnt, 6'd2);

      // No-bypass build shows old data until the edge.
      Sw = 1'b1; Sc = 5'd15; Sin = 32'hCAFEF00D; Sa = 5'd15;
      #1;
      chk("nb_old",  souta_nb, 32'd0);
      chk("byp_new", souta,    32'hCAFEF00D);
      step();
      idle(); Sa = 5'd15;
      #1 chk("nb_new", souta_nb, 32'hCAFEF00D);

      // Randomized traffic checked by the per-cycle compare.
      for (int n = 0; n < 3000; n++) begin
         step();
         Sw  = ($urandom_range(0, 99) < 45);
         Sr  = ($urandom_range(0, 99) < 50);
         Sc  = rnd_addr();
         Sd  = rnd_addr();
         Sa  = rnd_addr();
         Sb  = rnd_addr();
         Sin = $urandom;
      end

      // Asynchronous reset in mid-cycle after writing r5.
      step();
      idle(); Sw = 1'b1; Sc = 5'd5; Sin = 32'hDEADBEEF; Sr = 1'b1; Sd = 5'd9;
      step();
      idle(); Sa = 5'd5;
      #1 chk("pre_rst_souta", souta, 32'hDEADBEEF);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_souta", souta,    32'd0);
      chk("arst_busy",  busy,     32'd0);
      chk("arst_cnt",   busy_cnt, 6'd0);
      chk("arst_rdya",  rdya,     1'b1);
      step();
      rst_n = 1'b1;
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gpr_sb.md
Name: gpr_sb

Overview:
- Parametrised general-purpose register file: generation 2 of the single-write, dual-read GPR.
- Adds asynchronous reset, an optional hardwired zero register, optional write-to-read bypass, and a per-register busy scoreboard (reserve on issue, release on writeback).
- Sits between instruction issue and writeback; issue logic uses ready/reserve status to stall on read-after-write and write-after-write hazards.

Parameters:
- WIDTH, 32, data bits per register.
- DEPTH, 32, number of registers; power of two, >= 2.
- AW, $clog2(DEPTH), address width; localparam, not overridable.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports and ready flags.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Sw  in  1  write enable
- Sc  in  AW  write address
- Sin  in  WIDTH  write data
- Sa  in  AW  read address, port A
- Sb  in  AW  read address, port B
- Souta  out  WIDTH  read data, port A (combinational)
- Soutb  out  WIDTH  read data, port B (combinational)
- Rdya  out  1  register Sa holds valid data (combinational)
- Rdyb  out  1  register Sb holds valid data (combinational)
- Sr  in  1  reserve request
- Sd  in  AW  register to reserve
- Sr_ok  out  1  reserve accepted this cycle (combinational)
- busy  out  DEPTH  scoreboard vector, bit i = register i pending
- busy_cnt  out  AW+1  number of set busy bits (registered)

Behaviour:
- Reset: rst_n low clears all registers, busy and busy_cnt to 0 immediately, independent of clk. Souta/Soutb therefore read 0 and Rdya/Rdyb read 1.
- Reset deassertion is synchronised externally. Reset mid-reservation discards all pending reservations.
- Write: on rising clk with Sw=1, reg[Sc] <= Sin and busy[Sc] <= 0. Writing a non-busy register is a legal plain write.
- ZERO_REG=1 with Sc=0: no storage update; the busy bit stays 0.
- Read: Souta = reg[Sa]; Soutb = reg[Sb]; no clocked latency.
- ZERO_REG=1 with address 0: read data is 0.
- Bypass (BYPASS=1): if Sw=1, Sc==Sa, and not (ZERO_REG and Sa==0), then Souta = Sin and Rdya = 1 in the same cycle. Port B follows the same rule.
- Ready: Rdya = !busy[Sa] OR bypass hit on A. Rdyb uses the same rule for B. With BYPASS=0 the flags reflect only the pre-edge busy state.
- Reserve accept: Sr_ok = Sr AND (!busy[Sd] OR (Sw AND Sc==Sd)).
  - Reserving an already-busy register with no concurrent write is a WAW conflict: Sr_ok=0 and no state change.
- Reserve effect: on rising clk with Sr_ok=1, busy[Sd] <= 1.
  - Reserve wins over a simultaneous write to the same index: data is written and busy ends at 1.
  - ZERO_REG=1 with Sd=0: Sr_ok=1, but busy[0] stays 0.
- Write and reserve to different indices in the same cycle: both take effect.
- busy_cnt: next value = current + (reserve sets a clear bit) - (write clears a set bit). Net change is in {-1, 0, +1}. It never exceeds DEPTH (DEPTH-1 when ZERO_REG=1) and never goes negative.
- Addresses are always in range (DEPTH is a power of two); no wrap handling is required.
- No X propagation: every output is defined from reset onward.

Decomposition:
- gpr_pkg: default WIDTH/DEPTH constants, the ZERO_REG/BYPASS defaults, and a function that computes the busy_cnt next-delta.
- One sub-module, gpr_scoreboard: busy vector, Sr_ok, Rdya/Rdyb, busy_cnt.
- gpr_sb instantiates gpr_scoreboard alongside the storage array and bypass muxes.

Test Plan:
- Reset state: assert rst_n=0 mid-cycle after writing DEADBEEF to r5 → Souta=0 with Sa=5 immediately; busy=0; busy_cnt=0; Rdya=1.
- Zero register (ZERO_REG=1): write Sc=0, Sin=DEADBEEF → Souta=0 with Sa=0. Reserve Sd=0 → Sr_ok=1, busy[0]=0, busy_cnt unchanged.
- Reserve/release: reserve r5 → busy[5]=1, busy_cnt=1, Rdya=0 with Sa=5. Next cycle write r5=AAAA5555 → same cycle Rdya=1 and Souta=AAAA5555 (bypass). After the edge busy[5]=0 and busy_cnt=0.
- WAW block: with r10 busy, Sr=1, Sd=10, Sw=0 → Sr_ok=0, busy_cnt unchanged. Same request with Sw=1, Sc=10, Sin=12345678 → Sr_ok=1; after the edge reg[10]=12345678, busy[10]=1, busy_cnt unchanged.
- Simultaneous distinct: reserve r3 while writing r7=00000001 → busy[3]=1, reg[7]=1, and busy_cnt increments by 1.
- BYPASS=0 build: write r15=CAFEF00D with Sa=15 → Souta shows the old value (0) that cycle and CAFEF00D after the edge.
